// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS execution-trace recorder: FSM states, the stored
// per-cycle record, and the order in which a record is streamed out.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FULL    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] write_data;
    logic [3:0]  operation;
    logic        Zero;
  } trace_rec_t;

  localparam logic [1:0] BEAT_INSTR = 2'd0;
  localparam logic [1:0] BEAT_WDATA = 2'd1;
  localparam logic [1:0] BEAT_FLAGS = 2'd2;

  function automatic logic [31:0] beat_word(input trace_rec_t rec, input logic [1:0] beat);
    case (beat)
      BEAT_INSTR: beat_word = rec.instruction;
      BEAT_WDATA: beat_word = rec.write_data;
      default:    beat_word = {27'b0, rec.operation, rec.Zero};
    endcase
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: one write port clocked, one combinational read port.
// Contents are deliberately not reset.
module trace_ram
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  trace_rec_t       wr_rec,
  input  logic [AW-1:0]    rd_addr,
  output trace_rec_t       rd_rec
);

  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_rec;
    end
  end

  assign rd_rec = mem[rd_addr];

endmodule

// File: rtl/mips_trace_capture.sv
// Capture FSM, circular-buffer pointers and 3-beat read serializer for the
// single-cycle MIPS observation bundle.
module mips_trace_capture
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instruction,
  input  logic [31:0]            write_data,
  input  logic [3:0]             operation,
  input  logic                   Zero,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [31:0]            trig_instr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_data,
  output logic                   rd_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   capturing
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  trace_state_e  state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    beat_reg, beat_next;
  logic          overflow_reg, overflow_next;
  logic          wr_en;
  logic          rd_fire;
  logic          trig_hit;
  trace_rec_t    cur_rec;
  trace_rec_t    rd_rec;

  assign cur_rec  = {instruction, write_data, operation, Zero};
  assign trig_hit = !trig_en || (instruction == trig_instr);
  assign rd_valid = ((state_reg == IDLE) || (state_reg == FULL)) && (count_reg != '0);
  assign rd_fire  = rd_valid && rd_ready;

  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_rec  (cur_rec),
    .rd_addr (rd_ptr_reg),
    .rd_rec  (rd_rec)
  );

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    beat_next     = beat_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;

    // Reads only happen in IDLE/FULL, so they never race a capture write.
    if (rd_fire) begin
      if (beat_reg == BEAT_FLAGS) begin
        beat_next   = BEAT_INSTR;
        rd_ptr_next = rd_ptr_reg + 1'b1;
        count_next  = count_reg - 1'b1;
      end else begin
        beat_next = beat_reg + 1'b1;
      end
    end

    if (stop) begin
      if (state_reg != IDLE) begin
        state_next = IDLE;
      end
    end else if (arm) begin
      state_next    = ARMED;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      beat_next     = BEAT_INSTR;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (trig_hit) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            count_next  = count_reg + 1'b1;
            state_next  = CAPTURE;
          end
        end
        CAPTURE: begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          // Only reachable when wrapping: drop the oldest record in place.
          if (count_reg == FULL_CNT) begin
            rd_ptr_next   = rd_ptr_reg + 1'b1;
            overflow_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
            if (!WRAP && (count_reg == FULL_CNT - 1'b1)) begin
              state_next = FULL;
            end
          end
        end
        FULL: begin
          overflow_next = 1'b1;
          if (count_next == '0) begin
            state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_reg     <= BEAT_INSTR;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      beat_reg     <= beat_next;
      overflow_reg <= overflow_next;
    end
  end

  assign rd_data   = rd_valid ? beat_word(rd_rec, beat_reg) : 32'h0;
  assign rd_last   = rd_valid && (beat_reg == BEAT_FLAGS);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign capturing = (state_reg == ARMED) || (state_reg == CAPTURE);

endmodule

// File: tb/tb_mips_trace_capture.sv
// Bench for mips_trace_capture: directed table/sequences on a stop-at-full and
// a wrapping instance, then random traffic against a queue-based model.
module tb_mips_trace_capture;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] write_data;
  logic [3:0]  operation;
  logic        zero_in;
  logic        trig_en;
  logic [31:0] trig_instr;

  logic        arm, stop, rd_ready;
  logic        rd_valid, rd_last, overflow, capturing;
  logic [31:0] rd_data;
  logic [4:0]  count;

  logic        arm_w, stop_w, rd_ready_w;
  logic        rd_valid_w, rd_last_w, overflow_w, capturing_w;
  logic [31:0] rd_data_w;
  logic [4:0]  count_w;

  mips_trace_capture #(.DEPTH(DEPTH), .WRAP(1'b0)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .write_data(write_data),
    .operation(operation), .Zero(zero_in), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_instr(trig_instr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .count(count),
    .overflow(overflow), .capturing(capturing)
  );

  mips_trace_capture #(.DEPTH(DEPTH), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .instruction(instruction), .write_data(write_data),
    .operation(operation), .Zero(zero_in), .arm(arm_w), .stop(stop_w),
    .trig_en(trig_en), .trig_instr(trig_instr), .rd_valid(rd_valid_w),
    .rd_ready(rd_ready_w), .rd_data(rd_data_w), .rd_last(rd_last_w), .count(count_w),
    .overflow(overflow_w), .capturing(capturing_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs [16];

  // Reference model: stored records as a FIFO of 3-word tuples (word 0 first out).
  int               ms;      // 0 idle, 1 armed, 2 capture, 3 full
  logic [2:0][31:0] mq [$];
  int               mbeat;
  logic             movf;
  logic             ev, el, ecap;
  logic [31:0]      ed;
  logic [4:0]       ecnt;

  task automatic model_reset();
    ms = 0;
    mq.delete();
    mbeat = 0;
    movf = 1'b0;
  endtask

  task automatic model_expect();
    ev   = ((ms == 0) || (ms == 3)) && (mq.size() != 0);
    ed   = ev ? mq[0][mbeat] : 32'h0;
    el   = ev && (mbeat == 2);
    ecnt = 5'(mq.size());
    ecap = (ms == 1) || (ms == 2);
  endtask

  task automatic model_edge();
    logic [2:0][31:0] rec;
    rec = {{27'b0, operation, zero_in}, write_data, instruction};
    if (ev && rd_ready) begin
      if (mbeat == 2) begin
        $display("rand record out: instr=%h wdata=%h flags=%h", mq[0][0], mq[0][1], mq[0][2]);
        mq.delete(0);
        mbeat = 0;
      end else begin
        mbeat++;
      end
    end
    if (stop) begin
      ms = 0;
    end else if (arm) begin
      mq.delete();
      mbeat = 0;
      movf = 1'b0;
      ms = 1;
    end else begin
      case (ms)
        1: if (!trig_en || (instruction == trig_instr)) begin
             mq.push_back(rec);
             ms = 2;
           end
        2: begin
             mq.push_back(rec);
             if (mq.size() == DEPTH) ms = 3;
           end
        3: begin
             movf = 1'b1;
             if (mq.size() == 0) ms = 0;
           end
        default: ;
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] others [4];
    logic [31:0] exp_word;
    logic [31:0] act_v, exp_v;

    vecs[0]  = '{1'b1, 1'b1, 32'h02329820, 1'b0, 5'd3};
    vecs[1]  = '{1'b1, 1'b1, 32'h00000006, 1'b0, 5'd3};
    vecs[2]  = '{1'b1, 1'b1, 32'h00000004, 1'b1, 5'd3};
    vecs[3]  = '{1'b0, 1'b1, 32'h02329820, 1'b0, 5'd2};
    vecs[4]  = '{1'b1, 1'b1, 32'h02329820, 1'b0, 5'd2};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000006, 1'b0, 5'd2};
    vecs[6]  = '{1'b1, 1'b1, 32'h00000006, 1'b0, 5'd2};
    vecs[7]  = '{1'b0, 1'b1, 32'h00000004, 1'b1, 5'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000004, 1'b1, 5'd2};
    vecs[9]  = '{1'b0, 1'b1, 32'h02329820, 1'b0, 5'd1};
    vecs[10] = '{1'b1, 1'b1, 32'h02329820, 1'b0, 5'd1};
    vecs[11] = '{1'b0, 1'b1, 32'h00000006, 1'b0, 5'd1};
    vecs[12] = '{1'b1, 1'b1, 32'h00000006, 1'b0, 5'd1};
    vecs[13] = '{1'b0, 1'b1, 32'h00000004, 1'b1, 5'd1};
    vecs[14] = '{1'b1, 1'b1, 32'h00000004, 1'b1, 5'd1};
    vecs[15] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 5'd0};
    others[0] = 32'h20080001;
    others[1] = 32'h00000000;
    others[2] = 32'h8C0A0004;
    others[3] = 32'hAC0A0005;

    rst = 1'b0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    arm_w = 1'b0; stop_w = 1'b0; rd_ready_w = 1'b0;
    instruction = '0; write_data = '0; operation = '0; zero_in = 1'b0;
    trig_en = 1'b0; trig_instr = '0;

    // Reset state, before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_rd_last", 32'(rd_last), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_capturing", 32'(capturing), 32'd0);
    step();
    rst = 1'b0;

    // Basic capture, then table-driven readout with backpressure.
    arm = 1'b1; step(); arm = 1'b0;
    check("basic_armed", 32'(capturing), 32'd1);
    instruction = 32'h02329820; write_data = 32'd6; operation = 4'b0010; zero_in = 1'b0;
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("basic_count", 32'(count), 32'd3);
    check("basic_idle", 32'(capturing), 32'd0);
    for (int i = 0; i < 16; i++) begin
      $display("vec %0d: rdy=%0b valid=%0b data=%h last=%0b count=%0d", i, vecs[i].rdy,
               rd_valid, rd_data, rd_last, count);
      check("vec_valid", 32'(rd_valid), 32'(vecs[i].valid));
      check("vec_data", rd_data, vecs[i].data);
      check("vec_last", 32'(rd_last), 32'(vecs[i].last));
      check("vec_count", 32'(count), 32'(vecs[i].cnt));
      rd_ready = vecs[i].rdy;
      step();
    end
    rd_ready = 1'b0;

    // Trigger: only the matching cycle and later are captured.
    trig_en = 1'b1; trig_instr = 32'h8C0A0005;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instruction = others[i]; write_data = 32'(i); step();
    end
    check("trig_wait_count", 32'(count), 32'd0);
    check("trig_wait_capturing", 32'(capturing), 32'd1);
    instruction = 32'h8C0A0005; write_data = 32'hA5; step();
    instruction = 32'h20090002; write_data = 32'd7; step();
    instruction = 32'h20090003; write_data = 32'd8; step();
    stop = 1'b1; step(); stop = 1'b0; trig_en = 1'b0;
    $display("trigger: count=%0d first_instr=%h", count, rd_data);
    check("trig_count", 32'(count), 32'd3);
    check("trig_first_instr", rd_data, 32'h8C0A0005);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("trig_first_wdata", rd_data, 32'hA5);

    // arm and stop together: stop wins, no restart and no capture.
    arm = 1'b1; step(); arm = 1'b0;
    step(); step();
    arm = 1'b1; stop = 1'b1; step(); arm = 1'b0; stop = 1'b0;
    step(); step();
    $display("collision: capturing=%0b count=%0d", capturing, count);
    check("collide_capturing", 32'(capturing), 32'd0);
    check("collide_count", 32'(count), 32'd2);

    // Asynchronous reset mid-capture.
    arm = 1'b1; step(); arm = 1'b0;
    repeat (5) step();
    check("rstmid_count_before", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    $display("async reset: count=%0d capturing=%0b rd_valid=%0b", count, capturing, rd_valid);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_capturing", 32'(capturing), 32'd0);
    check("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    step();
    rst = 1'b0;

    // Stop at full (WRAP=0).
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      instruction = 32'h1000 + 32'(i); write_data = 32'(i); step();
    end
    $display("full: count=%0d overflow=%0b capturing=%0b", count, overflow, capturing);
    check("full_count", 32'(count), 32'd16);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_capturing", 32'(capturing), 32'd0);
    rd_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 3; b++) begin
        exp_word = (b == 0) ? 32'h1000 + 32'(r) : (b == 1) ? 32'(r) : 32'h4;
        check("full_rd_data", rd_data, exp_word);
        check("full_rd_last", 32'(rd_last), 32'(b == 2));
        step();
      end
    end
    rd_ready = 1'b0;
    check("full_drained_count", 32'(count), 32'd0);
    check("full_drained_valid", 32'(rd_valid), 32'd0);
    check("full_overflow_sticky", 32'(overflow), 32'd1);

    // Wrap (WRAP=1): oldest four records are overwritten.
    arm_w = 1'b1; step(); arm_w = 1'b0;
    for (int i = 0; i < 20; i++) begin
      instruction = 32'h2000 + 32'(i); write_data = 32'(i); step();
    end
    stop_w = 1'b1; step(); stop_w = 1'b0;
    $display("wrap: count=%0d overflow=%0b", count_w, overflow_w);
    check("wrap_count", 32'(count_w), 32'd16);
    check("wrap_overflow", 32'(overflow_w), 32'd1);
    rd_ready_w = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 3; b++) begin
        exp_word = (b == 0) ? 32'h2004 + 32'(r) : (b == 1) ? 32'(r + 4) : 32'h4;
        check("wrap_rd_data", rd_data_w, exp_word);
        check("wrap_rd_last", 32'(rd_last_w), 32'(b == 2));
        step();
      end
    end
    rd_ready_w = 1'b0;
    check("wrap_drained_count", 32'(count_w), 32'd0);
    check("wrap_drained_valid", 32'(rd_valid_w), 32'd0);

    // Random traffic against the model.
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    trig_instr = 32'h8C0A0005;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      model_expect();
      act_v = {25'b0, rd_valid, rd_last, overflow, capturing, 3'b0} ^ {27'b0, count};
      exp_v = {25'b0, ev, el, movf, ecap, 3'b0} ^ {27'b0, ecnt};
      checks++;
      if ((act_v !== exp_v) || (rd_data !== ed)) begin
        errors++;
        $display("FAIL rand cyc=%0d: got valid=%0b last=%0b ovf=%0b cap=%0b count=%0d data=%h expected valid=%0b last=%0b ovf=%0b cap=%0b count=%0d data=%h",
                 cyc, rd_valid, rd_last, overflow, capturing, count, rd_data,
                 ev, el, movf, ecap, ecnt, ed);
      end
      arm  = ($urandom_range(0, 99) < 2);
      stop = ($urandom_range(0, 99) < 2);
      if (arm && stop) arm = 1'b0;
      if (arm) trig_en = $urandom_range(0, 1) != 0;
      rd_ready    = ($urandom_range(0, 3) != 0);
      instruction = ($urandom_range(0, 7) == 0) ? 32'h8C0A0005 : $urandom;
      write_data  = $urandom;
      operation   = 4'($urandom_range(0, 15));
      zero_in     = $urandom_range(0, 1) != 0;
      model_edge();
      step();
    end
    arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_trace_capture.md
# mips_trace_capture

Execution-trace recorder for the single-cycle MIPS core. It samples the core's per-cycle observation bundle (`instruction`, `write_data`, `operation`, `Zero`) into an on-chip circular buffer, with an optional instruction-match trigger. It then streams the stored records out to a host or bench reader over a valid/ready word interface. It sits beside `monociclo_top`, replacing `$monitor`-style observation with a synthesizable capture path.

## Interface
Parameters:
- `DEPTH`, 16, number of trace records; power of two, ≥ 2.
- `WRAP`, 0, behaviour when the buffer is full: 0 = stop capture at full; 1 = overwrite the oldest record.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instruction`  in  32  current instruction from the core.
- `write_data`  in  32  current write-back data from the core.
- `operation`  in  4  current ALU operation code.
- `Zero`  in  1  current ALU zero flag.
- `arm`  in  1  single-cycle pulse; clears the buffer and starts a capture session.
- `stop`  in  1  single-cycle pulse; ends capture.
- `trig_en`  in  1  1 = wait for `instruction == trig_instr` before capturing.
- `trig_instr`  in  32  trigger match value.
- `rd_valid`  out  1  read beat available.
- `rd_ready`  in  1  reader accepts the beat.
- `rd_data`  out  32  read beat payload.
- `rd_last`  out  1  final beat (beat 2) of a record.
- `count`  out  $clog2(DEPTH)+1  number of stored records.
- `overflow`  out  1  sticky; a record was overwritten (WRAP=1) or dropped (WRAP=0).
- `capturing`  out  1  state is ARMED or CAPTURE.

## Operation
- State machine states: IDLE, ARMED, CAPTURE, FULL.
- IDLE on `arm`: wr_ptr, rd_ptr, count, beat and overflow all clear. Go to ARMED.
- ARMED: if `trig_en`=0, or `instruction==trig_instr`, write the current bundle in the same edge and go to CAPTURE. Otherwise remain in ARMED.
- CAPTURE: write one record every cycle.
- CAPTURE with WRAP=0: at the edge where count reaches DEPTH, go to FULL. Captures attempted in FULL set `overflow`.
- CAPTURE with WRAP=1: when full, each write advances rd_ptr, count stays at DEPTH, and `overflow` is set. FULL is never entered.
- `stop` in ARMED, CAPTURE or FULL: go to IDLE with no write on that edge.
- `stop` and `arm` in the same cycle: `stop` wins.
- `arm` from any state restarts the session; the buffer is cleared.
- Record layout:
  - beat 0 = `instruction`
  - beat 1 = `write_data`
  - beat 2 = {27'b0, `operation`, `Zero`}
- Readout:
  - `rd_valid` = (state is IDLE or FULL) && count ≠ 0.
  - `rd_data` is a combinational function of the record at rd_ptr and the beat counter.
- On `rd_valid && rd_ready`:
  - beat advances 0→1→2.
  - On beat 2, beat returns to 0, rd_ptr increments modulo DEPTH, and count decrements.
- FULL drains to IDLE when count reaches 0.
- Pointer width is $clog2(DEPTH); pointers wrap naturally. `count` carries one extra bit so that full is distinguishable from empty.
- Reset values:
  - state IDLE; pointers, beat and count 0; `overflow` 0.
  - `rd_valid`, `rd_last`, `capturing` 0; `rd_data` 0.
  - RAM contents are not reset.

## Timing
- Capture latency: the bundle present before edge N is stored at edge N. `count` reflects it after edge N.
- Trigger: the matching cycle itself is the first captured record.
- Read: a beat is consumed on the edge where `rd_valid && rd_ready`. Back-to-back beats are allowed, giving 3 cycles per record at full throughput.
- `rd_data` must remain stable while `rd_valid && !rd_ready`.
- Asynchronous `rst` mid-capture or mid-read aborts immediately. Outputs reach their reset values without waiting for a clock.

## Structure
- `mips_trace_pkg`:
  - `trace_state_e` (IDLE, ARMED, CAPTURE, FULL)
  - `trace_rec_t` packed struct {instruction, write_data, operation, Zero}, 69 bits
  - beat constants `BEAT_INSTR`=0, `BEAT_WDATA`=1, `BEAT_FLAGS`=2
- Sub-module `trace_ram`: simple dual-port, DEPTH × 69, synchronous write, asynchronous read, no reset.
- The FSM, pointers and read serializer stay in `mips_trace_capture`.

## Test plan
- **Reset:** assert `rst` mid-CAPTURE at count=5 → `count`=0, `capturing`=0, `rd_valid`=0 immediately, with no clock edge needed.
- **Basic capture:**
  - Stimulus: `arm`, `trig_en`=0; drive `instruction`=0x02329820, `write_data`=6, `operation`=4'b0010, `Zero`=0 for 3 cycles, then `stop`.
  - Response: `count`=3; readout yields 0x02329820, 0x00000006, 0x00000004 ×3, with `rd_last` on every third beat, then `rd_valid`=0.
- **Trigger:**
  - Stimulus: `trig_en`=1, `trig_instr`=0x8C0A0005; drive 4 other instructions, then the match, then 2 more; `stop`.
  - Response: `count`=3 and the first record instruction is 0x8C0A0005.
- **Stop at full (DEPTH=16, WRAP=0):** 20 capture cycles → state FULL, `count`=16, `overflow`=1; records 0–15 are read in order and the state returns to IDLE.
- **Wrap (WRAP=1):** 20 records with `write_data`=0..19 → `count`=16, `overflow`=1; readout starts at `write_data`=4 and ends at 19.
- **Backpressure and collisions:**
  - `rd_ready` toggling 1/0 → `rd_data` is held stable while stalled and no beat is skipped.
  - `arm` and `stop` in the same cycle → state IDLE.
